// File: rtl/lighthouse_sweep_sequencer_if.sv
// Bundle between the sweep sequencer, the interval detector, the sweep RAM and the sweep consumer.
// master = the sequencer, slave = everything around it.
interface lighthouse_sweep_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int IVL_W  = 32
);
  logic [IVL_W-1:0]  interval;
  logic              ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_q;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    input  interval, ready, ram_q, out_ready,
    output ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data
  );

  modport slave (
    output interval, ready, ram_q, out_ready,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data
  );
endinterface

// File: rtl/lighthouse_sweep_sequencer.sv
// Frame tracker + ring-buffer manager for lighthouse sweep delays, with prefetching pop port.
// Optional LH_SWEEP_TAG_EN: the RAM word MSB carries a frame parity bit instead of interval data.
module lighthouse_sweep_sequencer #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int IVL_W     = 32,
  parameter int SYNC_MAX  = 8,
  parameter int SWEEP_MAX = 120
) (
  input  logic                        clk,
  input  logic                        rst,
  lighthouse_sweep_sequencer_if.master bus,
  output logic [ADDR_W:0]             level,
  output logic                        overflow
);

  localparam int LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH     = LVL_W'(2**ADDR_W);
  localparam logic [IVL_W-1:0] SYNC_LIM  = IVL_W'(SYNC_MAX);
  localparam logic [IVL_W-1:0] SWEEP_LIM = IVL_W'(SWEEP_MAX);
`ifdef LH_SWEEP_TAG_EN
  localparam int PAY_W = DATA_W - 1;
`else
  localparam int PAY_W = DATA_W;
`endif
  localparam logic [IVL_W-1:0] PAY_MAX = IVL_W'((2**PAY_W) - 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNCED = 2'd1;
  localparam logic [1:0] SWEEP  = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_HOLD = 2'd2;

  logic [1:0]        fstate_reg, fstate_next;
  logic [1:0]        rstate_reg;
  logic [ADDR_W-1:0] wptr_reg, rptr_reg;
  logic [LVL_W-1:0]  level_reg, level_after;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              overflow_reg;
  logic [PAY_W-1:0]  payload;
  logic              is_sync, is_long, record, fetch, pop, full_at_commit, accept;

  assign is_sync = (bus.interval <= SYNC_LIM);
  assign is_long = (bus.interval > SWEEP_LIM);
  assign record  = bus.ready && (fstate_reg == SYNCED) && !is_sync && !is_long;

  always_comb begin
    fstate_next = fstate_reg;
    if (bus.ready) begin
      case (fstate_reg)
        HUNT:    if (is_sync) fstate_next = SYNCED;
        SYNCED:  if (is_sync)      fstate_next = SYNCED;
                 else if (is_long) fstate_next = HUNT;
                 else              fstate_next = SWEEP;
        SWEEP:   fstate_next = is_sync ? SYNCED : HUNT;
        default: fstate_next = HUNT;
      endcase
    end
  end

  assign fetch       = (rstate_reg == R_IDLE) && (level_reg != '0);
  assign pop         = (rstate_reg == R_HOLD) && valid_reg && bus.out_ready;
  assign level_after = level_reg + LVL_W'(we_reg) - LVL_W'(fetch);

  // The drop decision looks at the occupancy the write will land on next cycle;
  // a pop now guarantees a fetch in that same cycle, which frees the slot in time.
  assign full_at_commit = (level_after == DEPTH) && !pop;
  assign accept         = record && !full_at_commit;

  assign payload = (bus.interval > PAY_MAX) ? '1 : bus.interval[PAY_W-1:0];

`ifdef LH_SWEEP_TAG_EN
  logic tag_reg;

  assign wdata_next = {tag_reg, payload};

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg <= 1'b0;
    end else if (bus.ready && (fstate_reg == HUNT) && is_sync) begin
      tag_reg <= ~tag_reg;
    end
  end
`else
  assign wdata_next = payload;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate_reg   <= HUNT;
      rstate_reg   <= R_IDLE;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      level_reg    <= '0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      fstate_reg <= fstate_next;
      level_reg  <= level_after;
      we_reg     <= accept;
      if (accept) begin
        waddr_reg <= wptr_reg;
        wdata_reg <= wdata_next;
        wptr_reg  <= wptr_reg + ADDR_W'(1);
      end
      if (record && full_at_commit) overflow_reg <= 1'b1;

      case (rstate_reg)
        R_IDLE: if (fetch) begin
          rptr_reg   <= rptr_reg + ADDR_W'(1);
          rstate_reg <= R_WAIT;
        end
        R_WAIT: begin
          data_reg   <= bus.ram_q;
          valid_reg  <= 1'b1;
          rstate_reg <= R_HOLD;
        end
        R_HOLD: if (pop) begin
          valid_reg  <= 1'b0;
          rstate_reg <= R_IDLE;
        end
        default: rstate_reg <= R_IDLE;
      endcase
    end
  end

  assign bus.ram_we    = we_reg;
  assign bus.ram_waddr = waddr_reg;
  assign bus.ram_wdata = wdata_reg;
  assign bus.ram_raddr = rptr_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign level         = level_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_lighthouse_sweep_sequencer.sv
// Directed bench for lighthouse_sweep_sequencer with read-first RAM models; a second
// instance with SWEEP_MAX=400 exercises interval saturation.
module tb_lighthouse_sweep_sequencer;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int IVL_W  = 32;
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNCED = 2'd1;
`ifdef LH_SWEEP_TAG_EN
  localparam logic [7:0] FIRST_100 = 8'hE4;
`else
  localparam logic [7:0] FIRST_100 = 8'h64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lighthouse_sweep_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IVL_W(IVL_W)) bus ();
  lighthouse_sweep_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IVL_W(IVL_W)) bus2 ();

  logic [ADDR_W:0] level, level2;
  logic            overflow, overflow2;

  lighthouse_sweep_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IVL_W(IVL_W), .SYNC_MAX(8), .SWEEP_MAX(120)
  ) dut (.clk(clk), .rst(rst), .bus(bus), .level(level), .overflow(overflow));

  lighthouse_sweep_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IVL_W(IVL_W), .SYNC_MAX(8), .SWEEP_MAX(400)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2), .level(level2), .overflow(overflow2));

  logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem2 [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (bus2.ram_we) mem2[bus2.ram_waddr] <= bus2.ram_wdata;
    bus2.ram_q <= mem2[bus2.ram_raddr];
  end

  int we_count;
  always_ff @(posedge clk) begin
    if (rst) we_count <= 0;
    else if (bus.ram_we) we_count <= we_count + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] v);
    bus.interval = v;
    bus.ready    = 1'b1;
    tick();
    bus.ready    = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (bus.ram_we !== 1'b0)    begin n_bad++; $display("FAIL reset_ram_we: got %0b, expected 0", bus.ram_we); end
    n_cmp++; if (bus.ram_waddr !== 7'd0) begin n_bad++; $display("FAIL reset_ram_waddr: got %0d, expected 0", bus.ram_waddr); end
    n_cmp++; if (bus.ram_wdata !== 8'd0) begin n_bad++; $display("FAIL reset_ram_wdata: got %0d, expected 0", bus.ram_wdata); end
    n_cmp++; if (bus.ram_raddr !== 7'd0) begin n_bad++; $display("FAIL reset_ram_raddr: got %0d, expected 0", bus.ram_raddr); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'd0)  begin n_bad++; $display("FAIL reset_out_data: got %0d, expected 0", bus.out_data); end
    n_cmp++; if (level !== 8'd0)         begin n_bad++; $display("FAIL reset_level: got %0d, expected 0", level); end
    n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL reset_overflow: got %0b, expected 0", overflow); end
    n_cmp++; if (dut.fstate_reg !== ST_HUNT) begin n_bad++; $display("FAIL reset_fsm: got %0d, expected %0d", dut.fstate_reg, ST_HUNT); end
    rst = 1'b0;
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_basic();
    apply_reset();
    strobe(3);
    strobe(50);
    n_cmp++; if (bus.ram_we !== 1'b1)     begin n_bad++; $display("FAIL basic_we: got %0b, expected 1", bus.ram_we); end
    n_cmp++; if (bus.ram_waddr !== 7'd0)  begin n_bad++; $display("FAIL basic_waddr: got %0d, expected 0", bus.ram_waddr); end
    n_cmp++; if (bus.ram_wdata !== 8'd50) begin n_bad++; $display("FAIL basic_wdata: got %0d, expected 50", bus.ram_wdata); end
    tick();
    n_cmp++; if (level !== 8'd1)          begin n_bad++; $display("FAIL basic_level_n2: got %0d, expected 1", level); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL basic_valid_n3: got %0b, expected 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1)  begin n_bad++; $display("FAIL basic_valid_n4: got %0b, expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'd50)  begin n_bad++; $display("FAIL basic_data_n4: got %0d, expected 50", bus.out_data); end
    strobe(3);
    n_cmp++; if (dut.fstate_reg !== ST_SYNCED) begin n_bad++; $display("FAIL basic_fsm: got %0d, expected %0d", dut.fstate_reg, ST_SYNCED); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL basic_pop: got %0b, expected 0", bus.out_valid); end
    $display("test_basic: strobes 3,50,3 and one pop");
  endtask

  task automatic test_abort();
    int w0;
    apply_reset();
    w0 = we_count;
    strobe(50);
    strobe(3);
    n_cmp++; if (dut.fstate_reg !== ST_SYNCED) begin n_bad++; $display("FAIL abort_sync: got %0d, expected %0d", dut.fstate_reg, ST_SYNCED); end
    strobe(200);
    tick();
    tick();
    n_cmp++; if (we_count - w0 !== 0)    begin n_bad++; $display("FAIL abort_writes: got %0d, expected 0", we_count - w0); end
    n_cmp++; if (level !== 8'd0)         begin n_bad++; $display("FAIL abort_level: got %0d, expected 0", level); end
    n_cmp++; if (dut.fstate_reg !== ST_HUNT) begin n_bad++; $display("FAIL abort_fsm: got %0d, expected %0d", dut.fstate_reg, ST_HUNT); end
    $display("test_abort: strobes 50,3,200");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.ready = 1'b1;
    bus.interval = 3;  tick();
    bus.interval = 60; tick();
    bus.interval = 3;
    n_cmp++; if (bus.ram_we !== 1'b1)     begin n_bad++; $display("FAIL b2b_we0: got %0b, expected 1", bus.ram_we); end
    n_cmp++; if (bus.ram_wdata !== 8'd60) begin n_bad++; $display("FAIL b2b_wdata0: got %0d, expected 60", bus.ram_wdata); end
    tick();
    bus.interval = 70; tick();
    bus.ready = 1'b0;
    n_cmp++; if (bus.ram_we !== 1'b1)     begin n_bad++; $display("FAIL b2b_we1: got %0b, expected 1", bus.ram_we); end
    n_cmp++; if (bus.ram_waddr !== 7'd1)  begin n_bad++; $display("FAIL b2b_waddr1: got %0d, expected 1", bus.ram_waddr); end
    n_cmp++; if (bus.ram_wdata !== 8'd70) begin n_bad++; $display("FAIL b2b_wdata1: got %0d, expected 70", bus.ram_wdata); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd60) begin n_bad++; $display("FAIL b2b_out0: got v=%0b d=%0d, expected v=1 d=60", bus.out_valid, bus.out_data); end
    n_cmp++; if (level !== 8'd1)          begin n_bad++; $display("FAIL b2b_level: got %0d, expected 1", level); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd70) begin n_bad++; $display("FAIL b2b_out1: got v=%0b d=%0d, expected v=1 d=70", bus.out_valid, bus.out_data); end
    $display("test_back_to_back: ready held high over 3,60,3,70");
  endtask

  task automatic test_overflow();
    int w0;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 129; i++) begin
      strobe(3);
      strobe(32'(9 + (i % 112)));
      exp_q.push_back(8'(9 + (i % 112)));
    end
    tick(); tick(); tick();
    n_cmp++; if (level !== 8'd128)       begin n_bad++; $display("FAIL ovf_level: got %0d, expected 128", level); end
    n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL ovf_early: got %0b, expected 0", overflow); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin n_bad++; $display("FAIL ovf_head: got v=%0b d=%0d, expected v=1 d=%0d", bus.out_valid, bus.out_data, exp_q[0]); end
    w0 = we_count;
    strobe(3);
    strobe(99);
    tick(); tick();
    n_cmp++; if (we_count - w0 !== 0)    begin n_bad++; $display("FAIL ovf_dropped: got %0d writes, expected 0", we_count - w0); end
    n_cmp++; if (overflow !== 1'b1)      begin n_bad++; $display("FAIL ovf_set: got %0b, expected 1", overflow); end
    n_cmp++; if (level !== 8'd128)       begin n_bad++; $display("FAIL ovf_level_hold: got %0d, expected 128", level); end
    $display("test_overflow: 130 frames with consumer stalled");
  endtask

  task automatic test_full_pop();
    int popped;
    strobe(3);
    bus.interval  = 77;
    bus.ready     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.ready     = 1'b0;
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'd77);
    n_cmp++; if (bus.ram_we !== 1'b1)     begin n_bad++; $display("FAIL fullpop_we: got %0b, expected 1", bus.ram_we); end
    n_cmp++; if (bus.ram_waddr !== 7'd1)  begin n_bad++; $display("FAIL fullpop_waddr: got %0d, expected 1", bus.ram_waddr); end
    n_cmp++; if (bus.ram_wdata !== 8'd77) begin n_bad++; $display("FAIL fullpop_wdata: got %0d, expected 77", bus.ram_wdata); end
    tick();
    n_cmp++; if (level !== 8'd128)        begin n_bad++; $display("FAIL fullpop_level: got %0d, expected 128", level); end
    n_cmp++; if (overflow !== 1'b1)       begin n_bad++; $display("FAIL fullpop_sticky: got %0b, expected 1", overflow); end
    bus.out_ready = 1'b1;
    popped = 0;
    for (int c = 0; c < 1000 && exp_q.size() > 0; c++) begin
      if (bus.out_valid === 1'b1) begin
        logic [7:0] want;
        want = exp_q.pop_front();
        $display("pop %0d: data %0d", popped, bus.out_data);
        n_cmp++; if (bus.out_data !== want) begin n_bad++; $display("FAIL drain_word%0d: got %0d, expected %0d", popped, bus.out_data, want); end
        popped++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0)      begin n_bad++; $display("FAIL drain_timeout: got %0d popped, expected 129", popped); end
    n_cmp++; if (level !== 8'd0)         begin n_bad++; $display("FAIL drain_level: got %0d, expected 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %0b, expected 0", bus.out_valid); end
    $display("test_full_pop: record with pop while full, then drained %0d words", popped);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      strobe(3);
      strobe(32'(20 + i));
    end
    tick(); tick(); tick();
    n_cmp++; if (level !== 8'd5)         begin n_bad++; $display("FAIL rstmid_pre_level: got %0d, expected 5", level); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %0b, expected 1", bus.out_valid); end
    n_cmp++; if (overflow !== 1'b1)      begin n_bad++; $display("FAIL rstmid_pre_ovf: got %0b, expected 1", overflow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b, expected 0", bus.out_valid); end
    n_cmp++; if (level !== 8'd0)         begin n_bad++; $display("FAIL rstmid_level: got %0d, expected 0", level); end
    n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL rstmid_ovf: got %0b, expected 0", overflow); end
    n_cmp++; if (dut.fstate_reg !== ST_HUNT) begin n_bad++; $display("FAIL rstmid_fsm: got %0d, expected %0d", dut.fstate_reg, ST_HUNT); end
    $display("test_reset_mid: reset with word held and level 5");
  endtask

  task automatic test_saturate();
    apply_reset();
    bus2.interval = 3;
    bus2.ready    = 1'b1;
    tick();
    bus2.interval = 300;
    tick();
    bus2.ready    = 1'b0;
    // 300 clips to 255; with the parity tag the first frame's bit is 1, also giving 0xFF.
    n_cmp++; if (bus2.ram_we !== 1'b1)      begin n_bad++; $display("FAIL sat_we: got %0b, expected 1", bus2.ram_we); end
    n_cmp++; if (bus2.ram_wdata !== 8'hFF)  begin n_bad++; $display("FAIL sat_wdata: got %0d, expected 255", bus2.ram_wdata); end
    tick(); tick(); tick();
    n_cmp++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 8'hFF) begin n_bad++; $display("FAIL sat_out: got v=%0b d=%0d, expected v=1 d=255", bus2.out_valid, bus2.out_data); end
    $display("test_saturate: interval 300 on SWEEP_MAX=400 instance");
  endtask

  task automatic test_tag();
    apply_reset();
    strobe(3);
    strobe(100);
    n_cmp++; if (bus.ram_wdata !== FIRST_100) begin n_bad++; $display("FAIL tag_first: got %0h, expected %0h", bus.ram_wdata, FIRST_100); end
    strobe(200);
    n_cmp++; if (dut.fstate_reg !== ST_HUNT) begin n_bad++; $display("FAIL tag_hunt: got %0d, expected %0d", dut.fstate_reg, ST_HUNT); end
    strobe(3);
    strobe(100);
    n_cmp++; if (bus.ram_wdata !== 8'h64) begin n_bad++; $display("FAIL tag_second: got %0h, expected 64", bus.ram_wdata); end
    $display("test_tag: two frames of sweep 100");
  endtask

  initial begin
    bus.interval   = '0;
    bus.ready      = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.interval  = '0;
    bus2.ready     = 1'b0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_tag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
